// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline register chain.
// Mode selectors and the occupancy counter width.
package pipe_pkg;

  localparam bit PIPE_LOCKSTEP = 1'b0;
  localparam bit PIPE_ELASTIC  = 1'b1;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register: valid bit plus payload.
// Loads from upstream on load, otherwise holds minus any flush.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid/data register; a held stage drops its item when flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      data  <= up_data;
    end else begin
      valid <= valid & ~flush;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage register chain with valid/ready at both ends.
// Elastic mode collapses bubbles; lockstep advances as one unit.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 32,
  parameter bit ELASTIC = PIPE_ELASTIC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  input  logic [DEPTH-1:0]          flush,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int CW = count_w(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ev;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] nv;
  logic [WIDTH-1:0] data    [DEPTH];
  logic [WIDTH-1:0] up_data [DEPTH];
  logic             head_rdy;
  logic [CW-1:0]    pc;

  assign ev = valid & ~flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_valid[i] = in_valid;
      assign up_data[i]  = in_data;
    end else begin : g_body
      assign up_valid[i] = ev[i-1];
      assign up_data[i]  = data[i-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .load    (load[i]),
      .up_valid(up_valid[i]),
      .up_data (up_data[i]),
      .flush   (flush[i]),
      .valid   (valid[i]),
      .data    (data[i])
    );
  end

  if (ELASTIC == PIPE_ELASTIC) begin : g_el
    logic [DEPTH:0] rdy;
    assign rdy[DEPTH] = out_ready;
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
      assign rdy[i] = ~ev[i] | rdy[i+1];
    end
    assign load     = rdy[DEPTH-1:0];
    assign head_rdy = rdy[0];
  end else begin : g_ls
    logic adv;
    assign adv      = ~ev[DEPTH-1] | out_ready;
    assign load     = {DEPTH{adv}};
    assign head_rdy = adv;
  end

  assign in_ready  = head_rdy & ~reset;
  assign out_valid = ev[DEPTH-1] & ~reset;
  assign out_data  = data[DEPTH-1];

  assign nv = (load & up_valid) | (~load & ev);

  // Population count of the next-state valid vector.
  always_comb begin
    pc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pc = pc + CW'(nv[i]);
    end
  end

  // Occupancy register tracks the valid bits of the next cycle.
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= pc;
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: elastic and lockstep side by side
// against a slot-level reference model, plus directed scenarios.
module tb_pipe_reg_chain;

  localparam int D = 4;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rs;
  logic          iv;
  logic [W-1:0]  id;
  logic          orr;
  logic [D-1:0]  fl;

  logic          ire, ove, irl, ovl;
  logic [W-1:0]  ode, odl;
  logic [2:0]    cnte, cntl;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit acc_e;

  bit           ve [D];
  bit           vl [D];
  logic [W-1:0] de [D];
  logic [W-1:0] dl [D];

  logic [W-1:0] oqe [$];
  logic [W-1:0] oql [$];
  int           cqe [$];
  int           cql [$];

  always #5 clk = ~clk;

  pipe_reg_chain #(.DEPTH(D), .WIDTH(W), .ELASTIC(1'b1)) dut_e (
    .clk(clk), .reset(rs), .in_valid(iv), .in_ready(ire),
    .in_data(id), .out_valid(ove), .out_ready(orr),
    .out_data(ode), .flush(fl), .count(cnte)
  );

  pipe_reg_chain #(.DEPTH(D), .WIDTH(W), .ELASTIC(1'b0)) dut_l (
    .clk(clk), .reset(rs), .in_valid(iv), .in_ready(irl),
    .in_data(id), .out_valid(ovl), .out_ready(orr),
    .out_data(odl), .flush(fl), .count(cntl)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic step();
    bit le [D];
    bit ll [D];
    bit tv [D];
    logic [W-1:0] td [D];
    bit hole, x_ire, x_irl, x_ove, x_ovl, adv;
    int ce, cl;
    ce = 0;
    cl = 0;
    hole = 0;
    #1;
    for (int i = 0; i < D; i++) begin
      le[i] = ve[i] && !fl[i];
      ll[i] = vl[i] && !fl[i];
      ce += int'(ve[i]);
      cl += int'(vl[i]);
      if (!le[i]) hole = 1;
    end
    adv   = !ll[D-1] || orr;
    x_ire = !rs && (orr || hole);
    x_irl = !rs && adv;
    x_ove = !rs && le[D-1];
    x_ovl = !rs && ll[D-1];
    chk("e_in_ready", ire, x_ire);
    chk("e_out_valid", ove, x_ove);
    if (x_ove) chk("e_out_data", ode, de[D-1]);
    chk("e_count", cnte, ce);
    chk("l_in_ready", irl, x_irl);
    chk("l_out_valid", ovl, x_ovl);
    if (x_ovl) chk("l_out_data", odl, dl[D-1]);
    chk("l_count", cntl, cl);
    if (ove && orr) begin oqe.push_back(ode); cqe.push_back(cyc); end
    if (ovl && orr) begin oql.push_back(odl); cql.push_back(cyc); end
    acc_e = iv && x_ire;
    if (rs) begin
      for (int i = 0; i < D; i++) begin
        ve[i] = 0; vl[i] = 0; de[i] = '0; dl[i] = '0;
      end
    end else begin
      for (int i = 0; i < D; i++) begin
        tv[i] = le[i]; td[i] = de[i];
      end
      if (orr) tv[D-1] = 0;
      for (int i = D - 1; i >= 1; i--) begin
        if (!tv[i]) begin
          tv[i] = tv[i-1]; td[i] = td[i-1]; tv[i-1] = 0;
        end
      end
      if (!tv[0]) begin tv[0] = iv; td[0] = id; end
      for (int i = 0; i < D; i++) begin
        ve[i] = tv[i]; de[i] = td[i];
      end
      if (adv) begin
        for (int i = D - 1; i >= 1; i--) begin
          vl[i] = ll[i-1]; dl[i] = dl[i-1];
        end
        vl[0] = iv; dl[0] = id;
      end else begin
        for (int i = 0; i < D; i++) vl[i] = ll[i];
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drv(input bit v, input logic [W-1:0] d,
                     input bit o, input logic [D-1:0] f, input bit r);
    iv = v; id = d; orr = o; fl = f; rs = r;
    step();
  endtask

  task automatic clr();
    oqe.delete(); oql.delete(); cqe.delete(); cql.delete();
  endtask

  initial begin
    int p, k;
    bit first_acc;
    rs = 1; iv = 0; id = '0; orr = 0; fl = '0;
    for (int i = 0; i < D; i++) begin
      ve[i] = 0; vl[i] = 0; de[i] = '0; dl[i] = '0;
    end
    @(posedge clk);
    @(negedge clk);

    // reset with random inputs
    repeat (2) drv($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                   D'($urandom), 1);
    rs = 0; iv = 0; orr = 0; fl = '0;
    #1;
    chk("rst_in_ready_e", ire, 1);
    chk("rst_in_ready_l", irl, 1);
    chk("rst_count_e", cnte, 0);
    chk("rst_out_valid_e", ove, 0);
    step();

    // streaming
    drv(0, 0, 1, '0, 1);
    clr();
    p = cyc;
    drv(1, 32'h11, 1, '0, 0);
    drv(1, 32'h22, 1, '0, 0);
    drv(1, 32'h33, 1, '0, 0);
    repeat (6) drv(0, 0, 1, '0, 0);
    chk("stream_n_e", oqe.size(), 3);
    chk("stream_n_l", oql.size(), 3);
    for (int j = 0; j < 3; j++) begin
      chk("stream_d_e", oqe[j], 32'h11 * (j + 1));
      chk("stream_t_e", cqe[j], p + D + j);
      chk("stream_d_l", oql[j], 32'h11 * (j + 1));
      chk("stream_t_l", cql[j], p + D + j);
    end

    // backpressure then drain
    drv(0, 0, 0, '0, 1);
    clr();
    k = 0;
    repeat (6) begin
      drv(1, 32'hA0 + k, 0, '0, 0);
      if (acc_e) k++;
    end
    iv = 1; id = 32'hA4;
    #1;
    chk("bp_accepted", k, 4);
    chk("bp_count_e", cnte, 4);
    chk("bp_count_l", cntl, 4);
    chk("bp_in_ready_e", ire, 0);
    chk("bp_in_ready_l", irl, 0);
    step();
    first_acc = 0;
    for (int j = 0; j < 10; j++) begin
      drv(k < 5, 32'hA0 + k, 1, '0, 0);
      if (j == 0) first_acc = acc_e;
      if (acc_e) k++;
    end
    chk("bp_first_free", first_acc, 1);
    chk("bp_n_e", oqe.size(), 5);
    chk("bp_n_l", oql.size(), 5);
    for (int j = 0; j < 5; j++) begin
      chk("bp_d_e", oqe[j], 32'hA0 + j);
      chk("bp_d_l", oql[j], 32'hA0 + j);
    end

    // bubble collapse vs preserved gap
    drv(0, 0, 0, '0, 1);
    clr();
    drv(1, 32'hB0, 0, '0, 0);
    drv(0, 0, 0, '0, 0);
    drv(1, 32'hB1, 0, '0, 0);
    repeat (4) drv(0, 0, 0, '0, 0);
    #1;
    chk("bub_count_e", cnte, 2);
    chk("bub_count_l", cntl, 2);
    p = cyc;
    repeat (4) drv(0, 0, 1, '0, 0);
    chk("bub_d0_e", oqe[0], 32'hB0);
    chk("bub_d1_e", oqe[1], 32'hB1);
    chk("bub_t1_e", cqe[1], p + 1);
    chk("bub_d1_l", oql[1], 32'hB1);
    chk("bub_t1_l", cql[1], p + 2);

    // flush middle stages
    drv(0, 0, 0, '0, 1);
    clr();
    for (int j = 0; j < 4; j++) drv(1, 32'hC0 + j, 0, '0, 0);
    drv(0, 0, 0, 4'b0110, 0);
    #1;
    chk("fl_count_e", cnte, 2);
    chk("fl_count_l", cntl, 2);
    repeat (6) drv(0, 0, 1, '0, 0);
    chk("fl_n_e", oqe.size(), 2);
    chk("fl_d0_e", oqe[0], 32'hC0);
    chk("fl_d1_e", oqe[1], 32'hC3);
    chk("fl_n_l", oql.size(), 2);
    chk("fl_d1_l", oql[1], 32'hC3);

    // flush on last stage with out_ready
    drv(0, 0, 0, '0, 1);
    clr();
    for (int j = 0; j < 4; j++) drv(1, 32'hD0 + j, 0, '0, 0);
    drv(0, 0, 1, 4'b1000, 0);
    chk("fl_last_n_e", oqe.size(), 0);
    chk("fl_last_n_l", oql.size(), 0);

    // reset mid-flight
    drv(0, 0, 0, '0, 1);
    clr();
    for (int j = 0; j < 4; j++) drv(1, 32'hC0 + j, 0, '0, 0);
    drv(0, 0, 1, '0, 1);
    #1;
    chk("rmf_count_e", cnte, 0);
    chk("rmf_count_l", cntl, 0);
    chk("rmf_out_valid_e", ove, 0);
    chk("rmf_out_valid_l", ovl, 0);
    repeat (6) drv(0, 0, 1, '0, 0);
    chk("rmf_n_e", oqe.size(), 0);
    chk("rmf_n_l", oql.size(), 0);

    // random traffic
    for (int j = 0; j < 600; j++) begin
      drv($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 7,
          ($urandom_range(0, 7) == 0) ? D'($urandom) : '0,
          $urandom_range(0, 63) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
